tx_bus_sched: RTL and testbench

//  Transmit scheduler for the bus TX buffer. Takes the frame handed off by the frame

---
 rtl/nicsys_bus_pkg.sv | 21 ++
 rtl/crc16_byte.sv | 18 +
 rtl/tx_bus_sched.sv | 169 ++++++++++++++++
 tb/tb_tx_bus_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nicsys_bus_pkg.sv
// Shared bus-side definitions: scheduler state encoding, CRC-16/MODBUS constants
// and default frame limits.
package nicsys_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GAP       = 3'd1,
    ST_RD        = 3'd2,
    ST_WAIT      = 3'd3,
    ST_SEND      = 3'd4,
    ST_SEND_CRCL = 3'd5,
    ST_SEND_CRCH = 3'd6,
    ST_FLUSH     = 3'd7
  } tx_state_t;

  localparam logic [15:0] CRC16_POLY  = 16'hA001;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam int          DEF_MAX_LEN = 1024;
  localparam int          DEF_GAP_CYC = 16;

endpackage

// File: rtl/crc16_byte.sv
// One-byte step of reflected CRC-16 (poly 0xA001), purely combinational.
// Zero latency; no flow control.
module crc16_byte
  import nicsys_bus_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] next_crc
);

  always_comb begin
    next_crc = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      next_crc = next_crc[0] ? ((next_crc >> 1) ^ CRC16_POLY) : (next_crc >> 1);
    end
  end

endmodule

// File: rtl/tx_bus_sched.sv
// TX scheduler: inter-frame gap, then streams TX buffer bytes 0..len-1 to the serializer (TX_BUS_CRC_EN appends CRC-16).
// First rden GAP_CYC+1 cycles after tx_start; one byte per RD_LAT+2 cycles at best.
// Holds ser_valid/ser_data until ser_ready; starts while busy are rejected with tx_err.
module tx_bus_sched
  import nicsys_bus_pkg::*;
#(
  parameter int AW      = 11,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int RD_LAT  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tx_start,
  input  logic [AW-1:0] tx_data_len,
  output logic          tx_buf_rden,
  output logic [AW-1:0] tx_buf_raddr,
  input  logic [7:0]    tx_buf_rdata,
  output logic          ser_valid,
  output logic [7:0]    ser_data,
  input  logic          ser_ready,
  input  logic          ser_busy,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          tx_err
);

  localparam int            GW        = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [1:0]    LAT_LAST  = 2'(RD_LAT - 1);
  localparam logic [AW:0]   MAX_LEN_V = (AW+1)'(MAX_LEN);

  tx_state_t     state;
  logic [AW-1:0] len_q;
  logic [AW:0]   byte_cnt;
  logic [AW:0]   byte_cnt_inc;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    lat_cnt;
  logic          len_ok;
  logic          last_byte;

  assign len_ok       = (tx_data_len != '0) && ({1'b0, tx_data_len} <= MAX_LEN_V);
  assign byte_cnt_inc = byte_cnt + (AW+1)'(1);
  assign last_byte    = (byte_cnt_inc == {1'b0, len_q});

`ifdef TX_BUS_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_nxt;

  crc16_byte u_crc (
    .crc      (crc),
    .data     (ser_data),
    .next_crc (crc_nxt)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      lat_cnt      <= '0;
      tx_buf_rden  <= 1'b0;
      tx_buf_raddr <= '0;
      ser_valid    <= 1'b0;
      ser_data     <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
`ifdef TX_BUS_CRC_EN
      crc          <= CRC16_INIT;
`endif
    end else begin
      tx_buf_rden <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          // tx_done is still high in the first idle cycle, which counts as busy
          if (tx_start) begin
            if (tx_done || !len_ok) begin
              tx_err <= 1'b1;
            end else begin
              len_q    <= tx_data_len;
              byte_cnt <= '0;
              gap_cnt  <= '0;
              tx_busy  <= 1'b1;
              state    <= ST_GAP;
`ifdef TX_BUS_CRC_EN
              crc      <= CRC16_INIT;
`endif
            end
          end
        end
        ST_GAP: begin
          if (ser_busy) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            tx_buf_rden  <= 1'b1;
            tx_buf_raddr <= byte_cnt[AW-1:0];
            state        <= ST_RD;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_RD: begin
          lat_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            ser_data  <= tx_buf_rdata;
            ser_valid <= 1'b1;
            state     <= ST_SEND;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        ST_SEND: begin
          if (ser_ready) begin
            byte_cnt  <= byte_cnt_inc;
            ser_valid <= 1'b0;
`ifdef TX_BUS_CRC_EN
            crc       <= crc_nxt;
`endif
            if (last_byte) begin
`ifdef TX_BUS_CRC_EN
              ser_valid <= 1'b1;
              ser_data  <= crc_nxt[7:0];
              state     <= ST_SEND_CRCL;
`else
              state     <= ST_FLUSH;
`endif
            end else begin
              tx_buf_rden  <= 1'b1;
              tx_buf_raddr <= byte_cnt_inc[AW-1:0];
              state        <= ST_RD;
            end
          end
        end
`ifdef TX_BUS_CRC_EN
        ST_SEND_CRCL: begin
          if (ser_ready) begin
            ser_data <= crc[15:8];
            state    <= ST_SEND_CRCH;
          end
        end
        ST_SEND_CRCH: begin
          if (ser_ready) begin
            ser_valid <= 1'b0;
            state     <= ST_FLUSH;
          end
        end
`endif
        ST_FLUSH: begin
          if (!ser_busy) begin
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (tx_start && (state != ST_IDLE)) tx_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_bus_sched.sv
// Directed bench for tx_bus_sched: TX buffer model with RD_LAT read pipeline,
// byte scoreboard on the serializer handshake, timing and error-pulse checks.
module tb_tx_bus_sched;

  localparam int AW      = 11;
  localparam int MAX_LEN = 1024;
  localparam int GAP_CYC = 16;
  localparam int RD_LAT  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_start = 1'b0;
  logic [AW-1:0] tx_data_len = '0;
  logic          tx_buf_rden;
  logic [AW-1:0] tx_buf_raddr;
  logic [7:0]    tx_buf_rdata;
  logic          ser_valid;
  logic [7:0]    ser_data;
  logic          ser_ready = 1'b1;
  logic          ser_busy = 1'b0;
  logic          tx_busy;
  logic          tx_done;
  logic          tx_err;

  always #5 clk = ~clk;

  tx_bus_sched #(.AW(AW), .MAX_LEN(MAX_LEN), .GAP_CYC(GAP_CYC), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .tx_data_len  (tx_data_len),
    .tx_buf_rden  (tx_buf_rden),
    .tx_buf_raddr (tx_buf_raddr),
    .tx_buf_rdata (tx_buf_rdata),
    .ser_valid    (ser_valid),
    .ser_data     (ser_data),
    .ser_ready    (ser_ready),
    .ser_busy     (ser_busy),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_err       (tx_err)
  );

  // TX buffer RAM: data appears RD_LAT cycles after rden, junk otherwise
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    rd_pipe[0] <= tx_buf_rden ? mem[tx_buf_raddr] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign tx_buf_rdata = rd_pipe[RD_LAT-1];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rden_cnt = 0, done_cnt = 0, err_cnt = 0, rx_cnt = 0, rden_in_send = 0;
  int first_rden_cyc = -1;
  int start_cyc = 0;
  logic [7:0] exp_q [$];
  logic [7:0] fb [$];
  logic       prev_vld = 1'b0, prev_rdy = 1'b0;
  logic [7:0] prev_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (tx_buf_rden) begin
      rden_cnt++;
      if (first_rden_cyc < 0) first_rden_cyc = cyc;
      if (ser_valid) rden_in_send++;
    end
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (reset && prev_vld && !prev_rdy) begin
      chk("hold_valid", {31'd0, ser_valid}, 32'd1);
      chk("hold_data", {24'd0, ser_data}, {24'd0, prev_dat});
    end
    if (ser_valid && ser_ready) begin
      rx_cnt++;
      if (exp_q.size() != 0) chk("ser_data", {24'd0, ser_data}, {24'd0, exp_q.pop_front()});
    end
    prev_vld = ser_valid;
    prev_rdy = ser_ready;
    prev_dat = ser_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int len);
    tx_data_len    = AW'(len);
    tx_start       = 1'b1;
    start_cyc      = cyc;
    first_rden_cyc = -1;
    tick(1);
    tx_start = 1'b0;
  endtask

  task automatic load_frame();
    foreach (fb[i]) begin
      mem[i] = fb[i];
      exp_q.push_back(fb[i]);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (tx_done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, tx_done}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, e0, rd0, fall, n, nexp;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    tick(3);
    chk("rst_rden", {31'd0, tx_buf_rden}, 32'd0);
    chk("rst_raddr", {21'd0, tx_buf_raddr}, 32'd0);
    chk("rst_valid", {31'd0, ser_valid}, 32'd0);
    chk("rst_data", {24'd0, ser_data}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done_err", {30'd0, tx_done, tx_err}, 32'd0);
    reset = 1'b1;
    tick(2);

    // Basic 4-byte frame and gap timing
    fb = {8'hFE, 8'h0E, 8'h20, 8'h02};
    load_frame();
    d0 = done_cnt; r0 = rx_cnt;
    start(4);
    chk("t1_busy", {31'd0, tx_busy}, 32'd1);
    wait_done("t1_done", 500);
    tick(3);
    chk("t1_first_rden", first_rden_cyc - start_cyc, GAP_CYC + 1);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_bytes", rx_cnt - r0, 4);
    chk("t1_busy_clr", {31'd0, tx_busy}, 32'd0);

    // Illegal lengths
    e0 = err_cnt; rd0 = rden_cnt;
    start(0);
    chk("t2_err_len0", {31'd0, tx_err}, 32'd1);
    chk("t2_busy_len0", {31'd0, tx_busy}, 32'd0);
    tick(2);
    start(MAX_LEN + 1);
    chk("t2_err_big", {31'd0, tx_err}, 32'd1);
    tick(30);
    chk("t2_err_cnt", err_cnt - e0, 2);
    chk("t2_no_rden", rden_cnt - rd0, 0);
    chk("t2_busy", {31'd0, tx_busy}, 32'd0);

    // Largest legal frame
    fb.delete();
    for (int i = 0; i < MAX_LEN; i++) fb.push_back(8'($urandom));
    load_frame();
    r0 = rx_cnt;
    start(MAX_LEN);
    wait_done("t2b_done", 6000);
    tick(3);
    chk("t2b_bytes", rx_cnt - r0, MAX_LEN);
    chk("t2b_sb_empty", exp_q.size(), 0);

    // ser_busy in mid-gap restarts the gap
    fb = {8'h5A, 8'hA5};
    load_frame();
    r0 = rx_cnt;
    start(2);
    tick(5);
    ser_busy = 1'b1;
    tick(10);
    ser_busy = 1'b0;
    fall = cyc;
    wait_done("t3_done", 500);
    tick(3);
    chk("t3_gap_restart", first_rden_cyc - fall, GAP_CYC);
    chk("t3_bytes", rx_cnt - r0, 2);

    // Serializer backpressure
    fb = {8'h11, 8'h22, 8'h33};
    load_frame();
    r0 = rx_cnt;
    ser_ready = 1'b0;
    start(3);
    n = 0;
    while (!ser_valid && n < 100) begin
      tick(1);
      n++;
    end
    chk("t4_valid", {31'd0, ser_valid}, 32'd1);
    rd0 = rden_cnt;
    tick(5);
    chk("t4_no_rden", rden_cnt - rd0, 0);
    chk("t4_still_valid", {31'd0, ser_valid}, 32'd1);
    chk("t4_data_held", {24'd0, ser_data}, 32'h11);
    ser_ready = 1'b1;
    wait_done("t4_done", 500);
    tick(3);
    chk("t4_bytes", rx_cnt - r0, 3);

    // Start while busy, and start on the tx_done cycle
    fb = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    load_frame();
    e0 = err_cnt; d0 = done_cnt; r0 = rx_cnt;
    start(4);
    tick(20);
    start(2);
    chk("t5_err_busy", {31'd0, tx_err}, 32'd1);
    wait_done("t5_done", 500);
    rd0 = rden_cnt;
    tx_data_len = AW'(2);
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    chk("t5_err_on_done", {31'd0, tx_err}, 32'd1);
    chk("t5_busy_on_done", {31'd0, tx_busy}, 32'd0);
    tick(30);
    chk("t5_no_restart", rden_cnt - rd0, 0);
    chk("t5_err_cnt", err_cnt - e0, 2);
    chk("t5_done_once", done_cnt - d0, 1);
    chk("t5_bytes", rx_cnt - r0, 4);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Reset mid-frame, then a clean frame from address 0
    fb = {8'h71, 8'h72, 8'h73, 8'h74};
    load_frame();
    start(4);
    tick(22);
    reset = 1'b0;
    tick(1);
    chk("t5_reset_outs", {tx_buf_rden, ser_valid, tx_busy, tx_done, tx_err, tx_buf_raddr, ser_data}, 32'd0);
    reset = 1'b1;
    exp_q.delete();
    rd0 = rden_cnt;
    tick(5);
    chk("t5_idle_after_rst", rden_cnt - rd0, 0);
    fb = {8'h81, 8'h82};
    load_frame();
    r0 = rx_cnt;
    start(2);
    wait_done("t5_rst_done", 500);
    tick(3);
    chk("t5_rst_first_rden", first_rden_cyc - start_cyc, GAP_CYC + 1);
    chk("t5_rst_bytes", rx_cnt - r0, 2);

    // Modbus reference frame (CRC trailer when enabled)
    fb = {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    load_frame();
`ifdef TX_BUS_CRC_EN
    exp_q.push_back(8'h84);
    exp_q.push_back(8'h0A);
    nexp = 8;
`else
    nexp = 6;
`endif
    r0 = rx_cnt; d0 = done_cnt;
    start(6);
    wait_done("t6_done", 500);
    tick(3);
    chk("t6_bytes", rx_cnt - r0, nexp);
    chk("t6_done_once", done_cnt - d0, 1);
    chk("t6_sb_empty", exp_q.size(), 0);

    chk("no_rden_in_send", rden_in_send, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
